// File: rtl/mem_reader_pkg.sv
// mem_reader_pkg: shared types and default widths for the streaming memory reader.
//   state_t     FSM states of mem_stream_reader (IDLE, READ, DRAIN)
//   DEF_*       default ADDR_W / DATA_W / LEN_W / DEPTH parameter values
package mem_reader_pkg;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_LEN_W  = 11;
  localparam int unsigned DEF_DEPTH  = 512;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/mem_reader_skid.sv
// mem_reader_skid: 2-entry FIFO holding returned read data plus its last flag.
//   clk, rst_n             clock, async active-low reset
//   push/push_data/last    write one entry (caller guarantees room)
//   pop                    remove head entry (ignored when empty)
//   flush                  discard all entries; wins over push/pop
//   count                  number of stored entries (0..2)
//   head_valid/data/last   current head entry
module mem_reader_skid
  import mem_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last
);

  logic [DATA_W:0] slot_q [2];
  logic [DATA_W:0] slot_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            do_pop;

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        slot_d[wr_ptr_q] = {push_last, push_data};
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        slot_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_data  = slot_q[rd_ptr_q][DATA_W-1:0];
  assign head_last  = slot_q[rd_ptr_q][DATA_W];

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: drains a (start address, length) span of the dual-port
// byte memory through read port B and presents it as a valid/ready byte stream.
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/ready/addr/len       command handshake; len 0 completes at once
//   mem_enb/mem_addrb/mem_doutb    memory read port, 1-cycle read latency
//   m_valid/m_ready/m_data/m_last  output byte stream, m_last on final byte
//   done                           one-cycle pulse after command completion
//   abort                          only with MEM_READER_ABORT_EN defined:
//                                  cancels the active command and flushes data
module mem_stream_reader
  import mem_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
`ifdef MEM_READER_ABORT_EN
  input  logic              abort,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mem_enb,
  output logic [ADDR_W-1:0] mem_addrb,
  input  logic [DATA_W-1:0] mem_doutb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;
  logic             done_q, done_d;

  logic              abort_w;
  logic              flush;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;
  logic [1:0]        fifo_count;
  logic              head_valid;
  logic              head_last;
  logic [DATA_W-1:0] head_data;
  logic              unused_addr;

`ifdef MEM_READER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Address bits above the memory index are deliberately ignored.
  assign unused_addr = ^cmd_addr;

  always_comb begin
    pop       = head_valid && m_ready;
    // Reads issued now return into the FIFO next cycle; counting the in-flight
    // read and this cycle's pop keeps FIFO + in-flight at or below 2.
    occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    flush     = abort_w && (state_q != IDLE);
    issue     = (state_q == READ) && !abort_w && (occupancy < 3'd2);

    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    inflight_d      = issue;
    inflight_last_d = issue && (rem_q == LEN_W'(1));
    done_d          = 1'b0;

    if (flush) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = READ;
              addr_d  = cmd_addr[IDX_W-1:0];
              rem_d   = cmd_len;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_d = addr_q + IDX_W'(1);
            rem_d  = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  mem_reader_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (mem_doutb),
    .push_last (inflight_last_q),
    .pop       (pop),
    .flush     (flush),
    .count     (fifo_count),
    .head_valid(head_valid),
    .head_data (head_data),
    .head_last (head_last)
  );

  assign cmd_ready = (state_q == IDLE);
  assign mem_enb   = issue;
  assign mem_addrb = ADDR_W'(addr_q);
  assign m_valid   = head_valid;
  assign m_data    = head_data;
  assign m_last    = head_last;
  assign done      = done_q;

endmodule
